// File: rtl/vec3_pkg.sv
// Shared types, widths and per-op helpers for the vec3 operation sequencer.
// Optional feature macro: VEC3_SEQ_ORTHO_EN (enables op 6, ORTHO).
package vec3_pkg;

  localparam int OPW = 8;
  localparam int RESW = 16;

  typedef enum logic [2:0] {
    OP_ADD    = 3'd0,
    OP_SUB    = 3'd1,
    OP_CROSS  = 3'd2,
    OP_SCALAR = 3'd3,
    OP_DOT    = 3'd4,
    OP_ILL5   = 3'd5,
    OP_ORTHO  = 3'd6,
    OP_ILL7   = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic [2:0] step_count(input op_t op);
    return (op == OP_CROSS) ? 3'd6 : 3'd3;
  endfunction

  function automatic logic is_legal(input op_t op);
    case (op)
      OP_ADD, OP_SUB, OP_CROSS, OP_SCALAR, OP_DOT: return 1'b1;
`ifdef VEC3_SEQ_ORTHO_EN
      OP_ORTHO: return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/vec3_mul8.sv
// Combinational 8x8 -> 16 unsigned multiplier, time-shared by the sequencer.
module vec3_mul8
  import vec3_pkg::*;
(
  input  logic [OPW-1:0]  i_a,
  input  logic [OPW-1:0]  i_b,
  output logic [RESW-1:0] o_p
);

  assign o_p = RESW'(i_a) * RESW'(i_b);

endmodule

// File: rtl/vec3_op_sequencer.sv
// Multi-cycle 3D-vector ALU: one shared multiplier and one add/sub unit, one step per cycle.
// Optional feature macro: VEC3_SEQ_ORTHO_EN (ORTHO op and the ortho flag).
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready are both high;
// in_ready is high only in IDLE, out_valid only in DONE, and outputs hold until out_ready.
module vec3_op_sequencer
  import vec3_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [OPW-1:0]  ax,
  input  logic [OPW-1:0]  ay,
  input  logic [OPW-1:0]  az,
  input  logic [OPW-1:0]  bx,
  input  logic [OPW-1:0]  by,
  input  logic [OPW-1:0]  bz,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [RESW-1:0] rx,
  output logic [RESW-1:0] ry,
  output logic [RESW-1:0] rz,
  output logic [RESW-1:0] ans,
  output logic            ortho,
  output logic            err,
  output logic [1:0]      dbg_state
);

  state_t          r_state, w_next_state;
  op_t             r_op;
  logic            r_in_ready;
  logic [2:0]      r_step;
  logic [OPW-1:0]  r_ax, r_ay, r_az, r_bx, r_by, r_bz;
  logic [RESW-1:0] r_rx, r_ry, r_rz, r_ans, r_tmp;
  logic            r_err;
  logic            w_accept;
  logic [OPW-1:0]  w_ai, w_bi, w_mul_a, w_mul_b;
  logic [RESW-1:0] w_prod, w_as_a, w_as_b, w_as_y;
  logic            w_as_sub;

  assign w_accept = in_valid && r_in_ready;

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_next_state = ST_RUN;
      ST_RUN:  if (!is_legal(r_op) || r_step == step_count(r_op) - 3'd1) w_next_state = ST_DONE;
      ST_DONE: if (out_ready) w_next_state = ST_IDLE;
      default: w_next_state = ST_IDLE;
    endcase
  end

  // Component i of a and b for the element-wise ops.
  always_comb begin
    w_ai = r_az;
    w_bi = r_bz;
    case (r_step)
      3'd0: begin w_ai = r_ax; w_bi = r_bx; end
      3'd1: begin w_ai = r_ay; w_bi = r_by; end
      default: ;
    endcase
  end

  always_comb begin
    w_mul_a  = '0;
    w_mul_b  = '0;
    w_as_a   = '0;
    w_as_b   = '0;
    w_as_sub = 1'b0;
    case (r_op)
      OP_ADD, OP_SUB: begin
        w_as_a   = RESW'(w_ai);
        w_as_b   = RESW'(w_bi);
        w_as_sub = (r_op == OP_SUB);
      end
      OP_SCALAR: begin
        w_mul_a = w_ai;
        w_mul_b = r_bx;
      end
      OP_DOT, OP_ORTHO: begin
        w_mul_a = w_ai;
        w_mul_b = w_bi;
        w_as_a  = r_ans;
        w_as_b  = w_prod;
      end
      OP_CROSS: begin
        // Even steps produce the minuend (kept in r_tmp), odd steps the subtrahend.
        case (r_step)
          3'd0: begin w_mul_a = r_ay; w_mul_b = r_bz; end
          3'd1: begin w_mul_a = r_az; w_mul_b = r_by; end
          3'd2: begin w_mul_a = r_az; w_mul_b = r_bx; end
          3'd3: begin w_mul_a = r_ax; w_mul_b = r_bz; end
          3'd4: begin w_mul_a = r_ax; w_mul_b = r_by; end
          default: begin w_mul_a = r_ay; w_mul_b = r_bx; end
        endcase
        w_as_a   = r_tmp;
        w_as_b   = w_prod;
        w_as_sub = 1'b1;
      end
      default: ;
    endcase
  end

  vec3_mul8 u_mul (
    .i_a (w_mul_a),
    .i_b (w_mul_b),
    .o_p (w_prod)
  );

  assign w_as_y = w_as_sub ? (w_as_a - w_as_b) : (w_as_a + w_as_b);

`ifdef VEC3_SEQ_ORTHO_EN
  logic r_ortho;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                   r_ortho <= 1'b0;
    else if (w_accept)            r_ortho <= 1'b0;
    else if (r_state == ST_RUN && r_op == OP_ORTHO && r_step == 3'd2)
                                  r_ortho <= (w_as_y == '0);
  end
  assign ortho = r_ortho;
`else
  assign ortho = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= ST_IDLE;
      r_in_ready <= 1'b0;
      r_op       <= OP_ADD;
      r_step     <= '0;
      r_ax <= '0; r_ay <= '0; r_az <= '0;
      r_bx <= '0; r_by <= '0; r_bz <= '0;
      r_rx <= '0; r_ry <= '0; r_rz <= '0;
      r_ans <= '0; r_tmp <= '0;
      r_err <= 1'b0;
    end else begin
      r_state    <= w_next_state;
      r_in_ready <= (w_next_state == ST_IDLE);
      if (w_accept) begin
        r_op   <= op_t'(op);
        r_step <= '0;
        r_ax <= ax; r_ay <= ay; r_az <= az;
        r_bx <= bx; r_by <= by; r_bz <= bz;
        r_rx <= '0; r_ry <= '0; r_rz <= '0;
        r_ans <= '0; r_tmp <= '0;
        r_err <= 1'b0;
      end else if (r_state == ST_RUN) begin
        r_step <= r_step + 3'd1;
        if (!is_legal(r_op)) begin
          r_err <= 1'b1;
        end else begin
          case (r_op)
            OP_ADD, OP_SUB, OP_SCALAR: begin
              case (r_step)
                3'd0:    r_rx <= (r_op == OP_SCALAR) ? w_prod : w_as_y;
                3'd1:    r_ry <= (r_op == OP_SCALAR) ? w_prod : w_as_y;
                default: r_rz <= (r_op == OP_SCALAR) ? w_prod : w_as_y;
              endcase
            end
            OP_DOT, OP_ORTHO: r_ans <= w_as_y;
            OP_CROSS: begin
              if (!r_step[0]) r_tmp <= w_prod;
              else case (r_step[2:1])
                2'd0:    r_rx <= w_as_y;
                2'd1:    r_ry <= w_as_y;
                default: r_rz <= w_as_y;
              endcase
            end
            default: ;
          endcase
        end
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = (r_state == ST_DONE);
  assign rx        = r_rx;
  assign ry        = r_ry;
  assign rz        = r_rz;
  assign ans       = r_ans;
  assign err       = r_err;
  assign dbg_state = r_state;

endmodule
